matrix_transpose_buffer: RTL and testbench

MATRIX_TRANSPOSE_BUFFER -- requirements
Module: matrix_transpose_buffer

---
 rtl/mtb_pkg.sv | 11 +
 rtl/transpose_bank.sv | 39 +++
 rtl/matrix_transpose_buffer.sv | 125 ++++++++++++
 tb/tb_matrix_transpose_buffer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mtb_pkg.sv
// Shared encodings and sizing helpers for the matrix transpose buffer.
package mtb_pkg;

   localparam logic MODE_PASS      = 1'b0;
   localparam logic MODE_TRANSPOSE = 1'b1;

   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/transpose_bank.sv
// One N x N storage bank: row-wide write port, row or column read port.
module transpose_bank
   import mtb_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int N          = 8,
   parameter int CW         = 3
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [CW-1:0]         wr_idx,
   input  logic [N*DATA_WIDTH-1:0] wr_row,
   input  logic [CW-1:0]         rd_idx,
   input  logic                  rd_mode,
   output logic [N*DATA_WIDTH-1:0] rd_vec
);

   logic [N*DATA_WIDTH-1:0] mem_q [N];

   // Storage is deliberately not reset; validity lives in the full flags.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[wr_idx] <= wr_row;
      end
   end

   always_comb begin
      rd_vec = '0;
      if (rd_mode == MODE_TRANSPOSE) begin
         for (int r = 0; r < N; r++) begin
            rd_vec[r*DATA_WIDTH +: DATA_WIDTH] =
               mem_q[r][int'(rd_idx)*DATA_WIDTH +: DATA_WIDTH];
         end
      end else begin
         rd_vec = mem_q[rd_idx];
      end
   end

endmodule

// File: rtl/matrix_transpose_buffer.sv
// Ping-pong N x N buffer: rows in, rows or columns out, fill/drain overlapped.
module matrix_transpose_buffer
   import mtb_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int N          = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clear,
   input  logic                    in_val,
   output logic                    in_rdy,
   input  logic                    in_mode,
   input  logic [N*DATA_WIDTH-1:0] in_row,
   output logic                    out_val,
   input  logic                    out_rdy,
   output logic [N*DATA_WIDTH-1:0] out_vec,
   output logic                    out_last,
   output logic [1:0]              occupancy
);

   localparam int CW = cnt_w(N);
   localparam logic [CW-1:0] LAST = CW'(N-1);

   logic [1:0]    full_q, full_d;
   logic [1:0]    mode_q, mode_d;
   logic          wr_bank_q, wr_bank_d;
   logic          rd_bank_q, rd_bank_d;
   logic [CW-1:0] wr_cnt_q, wr_cnt_d;
   logic [CW-1:0] rd_cnt_q, rd_cnt_d;

   logic          accept;
   logic          pop;
   logic [1:0]    we;
   logic [N*DATA_WIDTH-1:0] bank_vec [2];

   assign in_rdy    = !full_q[wr_bank_q];
   assign out_val   = full_q[rd_bank_q];
   assign out_last  = out_val && (rd_cnt_q == LAST);
   assign occupancy = {1'b0, full_q[0]} + {1'b0, full_q[1]};
   assign out_vec   = rd_bank_q ? bank_vec[1] : bank_vec[0];

   assign accept = in_val && in_rdy;
   assign pop    = out_val && out_rdy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full_q    <= '0;
         mode_q    <= '0;
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
         wr_cnt_q  <= '0;
         rd_cnt_q  <= '0;
      end else begin
         full_q    <= full_d;
         mode_q    <= mode_d;
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         wr_cnt_q  <= wr_cnt_d;
         rd_cnt_q  <= rd_cnt_d;
      end
   end

   // Fill and drain always target different banks, so both flag edits can land.
   always_comb begin
      full_d    = full_q;
      mode_d    = mode_q;
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;
      wr_cnt_d  = wr_cnt_q;
      rd_cnt_d  = rd_cnt_q;
      if (accept) begin
         if (wr_cnt_q == '0) begin
            mode_d[wr_bank_q] = in_mode;
         end
         if (wr_cnt_q == LAST) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = !wr_bank_q;
            wr_cnt_d          = '0;
         end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
         end
      end
      if (pop) begin
         if (rd_cnt_q == LAST) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = !rd_bank_q;
            rd_cnt_d          = '0;
         end else begin
            rd_cnt_d = rd_cnt_q + 1'b1;
         end
      end
      if (clear) begin
         full_d    = '0;
         mode_d    = '0;
         wr_bank_d = 1'b0;
         rd_bank_d = 1'b0;
         wr_cnt_d  = '0;
         rd_cnt_d  = '0;
      end
   end

   always_comb begin
      we    = '0;
      we[0] = accept && !clear && (wr_bank_q == 1'b0);
      we[1] = accept && !clear && (wr_bank_q == 1'b1);
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      transpose_bank #(
         .DATA_WIDTH (DATA_WIDTH),
         .N          (N),
         .CW         (CW)
      ) u_bank (
         .clk     (clk),
         .we      (we[b]),
         .wr_idx  (wr_cnt_q),
         .wr_row  (in_row),
         .rd_idx  (rd_cnt_q),
         .rd_mode (mode_q[b]),
         .rd_vec  (bank_vec[b])
      );
   end

endmodule

// File: tb/tb_matrix_transpose_buffer.sv
// Randomised and directed checks of matrix_transpose_buffer (N=4, 16-bit).
module tb_matrix_transpose_buffer;

   localparam int DW = 16;
   localparam int N  = 4;

   typedef struct {
      logic [N*DW-1:0] v;
      logic            last;
   } vec_t;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            clear = 1'b0;
   logic            in_val = 1'b0;
   logic            in_rdy;
   logic            in_mode = 1'b0;
   logic [N*DW-1:0] in_row = '0;
   logic            out_val;
   logic            out_rdy = 1'b0;
   logic [N*DW-1:0] out_vec;
   logic            out_last;
   logic [1:0]      occupancy;

   int errors = 0;
   int checks = 0;

   vec_t            exp_q[$];
   logic [N*DW-1:0] part [N];
   int              pcnt = 0;
   logic            pmode = 1'b0;
   int              max_occ_seen = 0;

   matrix_transpose_buffer #(.DATA_WIDTH(DW), .N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .in_val    (in_val),
      .in_rdy    (in_rdy),
      .in_mode   (in_mode),
      .in_row    (in_row),
      .out_val   (out_val),
      .out_rdy   (out_rdy),
      .out_vec   (out_vec),
      .out_last  (out_last),
      .occupancy (occupancy)
   );

   always #5 clk = ~clk;

   function automatic int m_occ();
      return (exp_q.size() + N - 1) / N;
   endfunction

   function automatic logic [N*DW-1:0] mk_row(input int r, input int base);
      logic [N*DW-1:0] x;
      x = '0;
      for (int c = 0; c < N; c++) x[c*DW +: DW] = DW'(base + 16*r + c);
      return x;
   endfunction

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      pcnt = 0;
   endtask

   // Advance the model by one clock edge using the inputs just driven.
   task automatic model_step();
      logic            rdy;
      logic            val;
      vec_t            e;
      rdy = (m_occ() < 2);
      val = (exp_q.size() > 0);
      if (clear) begin
         model_reset();
         return;
      end
      if (val && out_rdy) void'(exp_q.pop_front());
      if (in_val && rdy) begin
         if (pcnt == 0) pmode = in_mode;
         part[pcnt] = in_row;
         pcnt++;
         if (pcnt == N) begin
            for (int k = 0; k < N; k++) begin
               e.v = '0;
               if (pmode) begin
                  for (int r = 0; r < N; r++) e.v[r*DW +: DW] = part[r][k*DW +: DW];
               end else begin
                  e.v = part[k];
               end
               e.last = (k == N-1);
               exp_q.push_back(e);
            end
            pcnt = 0;
         end
      end
      if (m_occ() > max_occ_seen) max_occ_seen = m_occ();
   endtask

   task automatic compare();
      logic val;
      val = (exp_q.size() > 0);
      chk("in_rdy", 64'(in_rdy), 64'(m_occ() < 2));
      chk("out_val", 64'(out_val), 64'(val));
      chk("occupancy", 64'(occupancy), 64'(m_occ()));
      chk("out_last", 64'(out_last), 64'(val && exp_q[0].last));
      if (val) chk("out_vec", 64'(out_vec), 64'(exp_q[0].v));
   endtask

   task automatic cycle(input logic iv, input logic md,
                        input logic [N*DW-1:0] row,
                        input logic ordy, input logic clr);
      @(negedge clk);
      compare();
      in_val  = iv;
      in_mode = md;
      in_row  = row;
      out_rdy = ordy;
      clear   = clr;
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n, input logic ordy);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, ordy, 1'b0);
   endtask

   task automatic feed(input int base, input logic md, input logic ordy);
      for (int r = 0; r < N; r++) cycle(1'b1, md, mk_row(r, base), ordy, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      in_val = 1'b0;
      out_rdy = 1'b0;
      clear = 1'b0;
      rst = 1'b1;
      #1;
      model_reset();
      chk("rst_out_val", 64'(out_val), 64'd0);
      chk("rst_in_rdy", 64'(in_rdy), 64'd1);
      chk("rst_occupancy", 64'(occupancy), 64'd0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      do_reset();
      chk("rst_out_last", 64'(out_last), 64'd0);

      // Transpose: first vector one cycle after row N-1 is taken.
      feed(0, 1'b1, 1'b1);
      chk("t_first_val", 64'(out_val), 64'd1);
      chk("t_vec0", 64'(out_vec), 64'h0030_0020_0010_0000);
      idle(1, 1'b1);
      chk("t_vec1", 64'(out_vec), 64'h0031_0021_0011_0001);
      idle(2, 1'b1);
      chk("t_vec3_last", 64'(out_last), 64'd1);
      chk("t_vec3", 64'(out_vec), 64'h0033_0023_0013_0003);
      idle(1, 1'b1);
      chk("t_drained", 64'(out_val), 64'd0);

      // Pass-through returns the rows in order.
      feed(0, 1'b0, 1'b1);
      chk("p_vec0", 64'(out_vec), 64'h0003_0002_0001_0000);
      idle(4, 1'b1);

      // Back-to-back matrices stream without stalling.
      max_occ_seen = 0;
      feed(0, 1'b1, 1'b1);
      feed(64, 1'b0, 1'b1);
      idle(5, 1'b1);
      chk("stream_max_occ", 64'(max_occ_seen), 64'd1);

      // Backpressure: both banks fill, then exactly one matrix frees a bank.
      for (int i = 0; i < 12; i++) cycle(1'b1, 1'(i / 4), mk_row(i % 4, 100), 1'b0, 1'b0);
      chk("bp_occupancy", 64'(occupancy), 64'd2);
      chk("bp_in_rdy", 64'(in_rdy), 64'd0);
      idle(3, 1'b1);
      chk("bp_in_rdy_3pops", 64'(in_rdy), 64'd0);
      idle(1, 1'b1);
      chk("bp_in_rdy_4pops", 64'(in_rdy), 64'd1);
      idle(5, 1'b1);

      // Clear drops a partial matrix; only the fresh one comes out.
      cycle(1'b1, 1'b1, mk_row(0, 7), 1'b1, 1'b0);
      cycle(1'b1, 1'b1, mk_row(1, 7), 1'b1, 1'b0);
      cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
      chk("clr_occupancy", 64'(occupancy), 64'd0);
      feed(200, 1'b0, 1'b1);
      chk("clr_fresh_vec0", 64'(out_vec), 64'(mk_row(0, 200)));
      idle(4, 1'b1);

      // Reset in the middle of draining.
      feed(0, 1'b1, 1'b0);
      idle(2, 1'b1);
      do_reset();
      idle(6, 1'b1);

      // Random traffic with occasional clears.
      for (int i = 0; i < 3000; i++) begin
         cycle(1'($urandom_range(0, 3) != 0), 1'($urandom()),
               {$urandom(), $urandom()}, 1'($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 127) == 0));
      end
      idle(12, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
